arraysum_collector: RTL and testbench



---
 rtl/arraysum_if.sv | 33 +++
 rtl/arraysum_collector.sv | 134 +++++++++++++
 tb/tb_arraysum_collector.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/arraysum_if.sv
// Bundle between the array-add stage, the collector and the result consumer.
//   run/index/sum       : one element per cycle while run is high
//   res_valid/res_ready : result handshake
//   res_total/max/count : pass result, stable while res_valid is high
//   busy/seq_err        : status (accumulating / index discontinuity seen)
interface arraysum_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned ACC_W  = 40
);
  logic              run;
  logic [IDX_W-1:0]  index;
  logic [DATA_W-1:0] sum;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_total;
  logic [DATA_W-1:0] res_max;
  logic [IDX_W:0]    res_count;
  logic              busy;
  logic              seq_err;

  // Upstream adder plus result consumer.
  modport master (
    output run, index, sum, res_ready,
    input  res_valid, res_total, res_max, res_count, busy, seq_err
  );

  // The collector.
  modport slave (
    input  run, index, sum, res_ready,
    output res_valid, res_total, res_max, res_count, busy, seq_err
  );
endinterface

// File: rtl/arraysum_collector.sv
// Collects one full pass of 2^IDX_W elements from the array-add stage,
// accumulates the total and the maximum, and offers the result on a
// valid/ready port. Index discontinuities set a sticky seq_err.
// Ports: clk, rst_n (async, active low), bus (arraysum_if.slave).
module arraysum_collector #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned ACC_W  = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  arraysum_if.slave  bus
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  total_q, total_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  expected_q, expected_d;
  logic              seq_err_q, seq_err_d;
  logic              busy_q, busy_d;
  logic              res_valid_q, res_valid_d;
  logic [ACC_W-1:0]  res_total_q, res_total_d;
  logic [DATA_W-1:0] res_max_q, res_max_d;
  logic [CNT_W-1:0]  res_count_q, res_count_d;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      total_q     <= '0;
      max_q       <= '0;
      count_q     <= '0;
      expected_q  <= '0;
      seq_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_total_q <= '0;
      res_max_q   <= '0;
      res_count_q <= '0;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      max_q       <= max_d;
      count_q     <= count_d;
      expected_q  <= expected_d;
      seq_err_q   <= seq_err_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_total_q <= res_total_d;
      res_max_q   <= res_max_d;
      res_count_q <= res_count_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    max_d       = max_q;
    count_d     = count_q;
    expected_d  = expected_q;
    seq_err_d   = seq_err_q;
    res_valid_d = res_valid_q;
    res_total_d = res_total_q;
    res_max_d   = res_max_q;
    res_count_d = res_count_q;

    unique case (state_q)
      IDLE: begin
        // Only an element at index 0 aligns us to a pass.
        if (bus.run && (bus.index == '0)) begin
          total_d    = ACC_W'(bus.sum);
          max_d      = bus.sum;
          count_d    = CNT_W'(1);
          expected_d = IDX_W'(1);
          seq_err_d  = 1'b0;
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.run) begin
          total_d = total_q + ACC_W'(bus.sum);
          if (bus.sum > max_q) begin
            max_d = bus.sum;
          end
          count_d = count_q + CNT_W'(1);
          if (bus.index != expected_q) begin
            seq_err_d = 1'b1;
          end
          // Resync on the observed index; equals expected+1 on a clean step.
          expected_d = bus.index + IDX_W'(1);
          if (bus.index == LAST_IDX) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // First HOLD cycle publishes the result; afterwards wait for accept.
        if (!res_valid_q) begin
          res_valid_d = 1'b1;
          res_total_d = total_q;
          res_max_d   = max_q;
          res_count_d = count_q;
        end else if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == ACCUM);
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_total = res_total_q;
  assign bus.res_max   = res_max_q;
  assign bus.res_count = res_count_q;
  assign bus.busy      = busy_q;
  assign bus.seq_err   = seq_err_q;

endmodule

// File: tb/tb_arraysum_collector.sv
// Self-checking bench for arraysum_collector: an upstream adder stream with
// scenario-specific run/sum/index/ready patterns, checked every cycle against
// a pass-level reference model (captured elements kept in a queue, results
// computed by reduction when the pass completes).
module tb_arraysum_collector;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = 8;
  localparam int unsigned ACC_W  = 40;

  localparam int K_CLEAN = 0;
  localparam int K_ONES  = 1;
  localparam int K_PAUSE = 2;
  localparam int K_HOLD  = 3;
  localparam int K_SKIP  = 4;
  localparam int K_RAND  = 5;

  logic clk;
  logic rst_n;

  arraysum_if #(.DATA_W(DATA_W), .IDX_W(IDX_W), .ACC_W(ACC_W)) bus ();

  arraysum_collector #(.DATA_W(DATA_W), .IDX_W(IDX_W), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: 0 waiting for index 0, 1 collecting, 2 pass complete
  // (result not yet offered), 3 result offered.
  int          m_phase = 0;
  logic [31:0] m_sums[$];
  logic [7:0]  m_last;
  bit          m_err;
  logic [63:0] m_total;
  logic [31:0] m_max;
  int          m_count;

  logic [7:0]  up_idx = 8'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 64'(bus.res_valid), 64'd0);
    check({tag, "_total"}, 64'(bus.res_total), 64'd0);
    check({tag, "_max"},   64'(bus.res_max),   64'd0);
    check({tag, "_count"}, 64'(bus.res_count), 64'd0);
    check({tag, "_busy"},  64'(bus.busy),      64'd0);
    check({tag, "_err"},   64'(bus.seq_err),   64'd0);
  endtask

  // Reduce the captured pass into the expected result.
  task automatic model_finish();
    m_total = 64'd0;
    m_max   = 32'd0;
    foreach (m_sums[k]) begin
      m_total = m_total + 64'(m_sums[k]);
      if (m_sums[k] > m_max) m_max = m_sums[k];
    end
    m_count = m_sums.size();
  endtask

  // One clock: apply inputs, advance the model over the edge, check after it.
  task automatic cyc(input logic r, input logic [7:0] idx, input logic [31:0] s, input logic rdy);
    bus.run       = r;
    bus.index     = idx;
    bus.sum       = s;
    bus.res_ready = rdy;
    case (m_phase)
      0: if (r && idx == 8'd0) begin
           m_sums.delete();
           m_sums.push_back(s);
           m_err   = 1'b0;
           m_last  = idx;
           m_phase = 1;
         end
      1: if (r) begin
           if (idx != 8'(m_last + 8'd1)) m_err = 1'b1;
           m_last = idx;
           m_sums.push_back(s);
           if (idx == 8'hFF) m_phase = 2;
         end
      2: begin
           model_finish();
           m_phase = 3;
         end
      default: if (rdy) m_phase = 0;
    endcase
    @(posedge clk);
    #1;
    check("busy",  64'(bus.busy),      64'(m_phase == 1));
    check("valid", 64'(bus.res_valid), 64'(m_phase == 3));
    if (m_phase != 0) check("seq_err", 64'(bus.seq_err), 64'(m_err));
    if (m_phase == 3) begin
      check("total", 64'(bus.res_total), 64'(m_total[ACC_W-1:0]));
      check("max",   64'(bus.res_max),   64'(m_max));
      check("count", 64'(bus.res_count), 64'(m_count));
    end
  endtask

  // Drive the upstream stream until one result has been offered and accepted.
  task automatic do_pass(input int kind);
    bit          seen_valid = 0;
    bit          first      = 1;
    bit          paused     = 0;
    int          pause_left = 0;
    int          hold_cnt   = 0;
    int          budget     = 0;
    logic        r;
    logic        rdy;
    logic [31:0] s;
    while (!(seen_valid && m_phase == 0)) begin
      if (budget++ > 3000) begin
        check("timeout", 64'd1, 64'd0);
        break;
      end
      if (m_phase == 3 && first) begin
        first = 0;
        case (kind)
          K_CLEAN, K_PAUSE, K_HOLD: begin
            check("c_total", 64'(bus.res_total), 64'h8080);
            check("c_max",   64'(bus.res_max),   64'd256);
            check("c_count", 64'(bus.res_count), 64'd256);
            check("c_err",   64'(bus.seq_err),   64'd0);
          end
          K_ONES: begin
            check("o_total", 64'(bus.res_total), 64'hFF_FFFF_FF00);
            check("o_max",   64'(bus.res_max),   64'hFFFF_FFFF);
            check("o_count", 64'(bus.res_count), 64'd256);
          end
          K_SKIP: begin
            check("s_total", 64'(bus.res_total), 64'h804D);
            check("s_count", 64'(bus.res_count), 64'd255);
            check("s_err",   64'(bus.seq_err),   64'd1);
          end
          default: ;
        endcase
      end
      r = 1'b1;
      if (kind == K_PAUSE && m_phase == 1 && up_idx == 8'd100 && !paused) begin
        paused     = 1;
        pause_left = 10;
      end
      if (pause_left > 0) begin
        r = 1'b0;
        pause_left--;
      end
      if (kind == K_RAND) r = ($urandom_range(3) != 0);
      case (kind)
        K_ONES:  s = 32'hFFFF_FFFF;
        K_RAND:  s = $urandom;
        default: s = 32'(up_idx) + 32'd1;
      endcase
      rdy = 1'b1;
      if (kind == K_HOLD) begin
        rdy = (hold_cnt >= 20);
        if (m_phase == 3) hold_cnt++;
      end
      if (kind == K_RAND) rdy = 1'($urandom_range(1));
      cyc(r, up_idx, s, rdy);
      if (m_phase == 3) seen_valid = 1;
      if (r) begin
        if (kind == K_SKIP && up_idx == 8'd49 && m_phase == 1) up_idx = 8'd51;
        else up_idx = up_idx + 8'd1;
      end
    end
  endtask

  initial begin
    int budget;
    rst_n         = 1'b0;
    bus.run       = 1'b0;
    bus.index     = '0;
    bus.sum       = '0;
    bus.res_ready = 1'b0;
    #12;
    check_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    do_pass(K_CLEAN);
    do_pass(K_ONES);
    do_pass(K_PAUSE);
    do_pass(K_HOLD);
    do_pass(K_SKIP);
    do_pass(K_CLEAN);

    // Asynchronous reset in the middle of a pass.
    budget = 0;
    while (!(m_phase == 1 && up_idx == 8'd128)) begin
      if (budget++ > 1000) begin
        check("rst_timeout", 64'd1, 64'd0);
        break;
      end
      cyc(1'b1, up_idx, 32'(up_idx) + 32'd1, 1'b1);
      up_idx = up_idx + 8'd1;
    end
    check("pre_rst_busy", 64'(bus.busy), 64'd1);
    #2;
    rst_n   = 1'b0;
    bus.run = 1'b0;
    #1;
    check_zero("mid_rst");
    m_phase = 0;
    up_idx  = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    do_pass(K_CLEAN);

    for (int i = 0; i < 4; i++) do_pass(K_RAND);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
